// File: rtl/inst_prefetch_buf.sv
// inst_prefetch_buf: instruction fetch front end between inst_rom and the IF stage.
// Owns the fetch PC, drives the ROM, and queues {pc, inst} pairs in a small FIFO
// that the core drains over a valid/ready handshake. A redirect flushes the
// queue and restarts fetch at the word-aligned target.
module inst_prefetch_buf #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                     clk,
  input  logic                     rst,
  output logic                     rom_ce_o,
  output logic [31:0]              rom_addr_o,
  input  logic [31:0]              rom_data_i,
  output logic                     inst_valid_o,
  input  logic                     inst_ready_i,
  output logic [31:0]              inst_o,
  output logic [31:0]              pc_o,
  input  logic                     redirect_i,
  input  logic [31:0]              redirect_addr_i,
  output logic [$clog2(DEPTH):0]   level_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_LEVEL = CW'(DEPTH);

  logic [31:0]   fpc;
  logic [31:0]   mem_pc   [DEPTH];
  logic [31:0]   mem_inst [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic          push;
  logic          pop;

  // Fetch is throttled only by occupancy; the core's ready never reaches the ROM
  // enable, so a full queue waits one cycle after a pop before fetching again.
  assign rom_ce_o     = !rst && !redirect_i && (count < FULL_LEVEL);
  assign rom_addr_o   = rst ? RESET_PC : fpc;
  assign inst_valid_o = (count != '0) && !rst;
  assign push         = rom_ce_o;
  assign pop          = inst_valid_o && inst_ready_i && !redirect_i;

  assign inst_o  = inst_valid_o ? mem_inst[rd_ptr] : 32'h0;
  assign pc_o    = inst_valid_o ? mem_pc[rd_ptr]   : 32'h0;
  assign level_o = rst ? '0 : count;

  // Fetch PC: reset, redirect target (word aligned), or advance on each fetch.
  always_ff @(posedge clk) begin
    if (rst) begin
      fpc <= RESET_PC;
    end else if (redirect_i) begin
      fpc <= redirect_addr_i & 32'hFFFF_FFFC;
    end else if (push) begin
      fpc <= fpc + 32'd4;
    end
  end

  // Queue bookkeeping: pointers and occupancy, flushed by reset or redirect.
  always_ff @(posedge clk) begin
    if (rst || redirect_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + AW'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are don't-care after reset so no reset here.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_pc[wr_ptr]   <= fpc;
      mem_inst[wr_ptr] <= rom_data_i;
    end
  end

endmodule

// File: tb/tb_inst_prefetch_buf.sv
// Directed bench for inst_prefetch_buf: a per-cycle vector table covering reset,
// free run, backpressure fill, redirects, PC wrap and mid-stream reset, followed
// by a hand-written steady-state streaming sequence.
module tb_inst_prefetch_buf;

  localparam int DEPTH = 4;
  localparam logic [31:0] KEY = 32'hA5A5_A5A5;

  logic        clk = 1'b0;
  logic        rst;
  logic        rom_ce;
  logic [31:0] rom_addr;
  logic [31:0] rom_data;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        redirect;
  logic [31:0] redirect_addr;
  logic [$clog2(DEPTH):0] level;

  int pass_cnt = 0;
  int total_cnt = 0;
  int seen_pc40 = 0;

  always #5 clk = ~clk;

  // ROM model: word at address A is A ^ KEY.
  assign rom_data = rom_addr ^ KEY;

  inst_prefetch_buf #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .rom_ce_o       (rom_ce),
    .rom_addr_o     (rom_addr),
    .rom_data_i     (rom_data),
    .inst_valid_o   (inst_valid),
    .inst_ready_i   (inst_ready),
    .inst_o         (inst),
    .pc_o           (pc),
    .redirect_i     (redirect),
    .redirect_addr_i(redirect_addr),
    .level_o        (level)
  );

  always @(negedge clk) begin
    if (inst_valid && pc == 32'h40) seen_pc40++;
  end

  typedef struct {
    logic        rst;
    logic        ready;
    logic        redir;
    logic [31:0] raddr;
    logic        ce;
    logic [31:0] addr;
    logic        valid;
    logic [31:0] pc;
    int          level;
  } vec_t;

  vec_t vt[$];

  task automatic add(input logic r, input logic rdy, input logic rd, input logic [31:0] ra,
                     input logic ce, input logic [31:0] a, input logic v,
                     input logic [31:0] p, input int l);
    vec_t x;
    x.rst = r; x.ready = rdy; x.redir = rd; x.raddr = ra;
    x.ce = ce; x.addr = a; x.valid = v; x.pc = p; x.level = l;
    vt.push_back(x);
  endtask

  task automatic chk32(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s vec%0d: got %h expected %h", name, idx, act, exp);
  endtask

  initial begin
    logic [31:0] exp_pc;

    //   rst rdy red raddr          ce  addr          v   pc            lvl
    add(1, 0, 0, 32'h0,            0, 32'h0,        0, 32'h0,        0); // 0 reset
    add(0, 1, 0, 32'h0,            1, 32'h0,        0, 32'h0,        0); // 1 first fetch
    add(0, 1, 0, 32'h0,            1, 32'h4,        1, 32'h0,        1); // 2
    add(0, 1, 0, 32'h0,            1, 32'h8,        1, 32'h4,        1); // 3
    add(0, 0, 0, 32'h0,            1, 32'hC,        1, 32'h8,        1); // 4 backpressure
    add(0, 0, 0, 32'h0,            1, 32'h10,       1, 32'h8,        2); // 5
    add(0, 0, 0, 32'h0,            1, 32'h14,       1, 32'h8,        3); // 6
    add(0, 0, 0, 32'h0,            0, 32'h18,       1, 32'h8,        4); // 7 full
    add(0, 1, 0, 32'h0,            0, 32'h18,       1, 32'h8,        4); // 8 pop while full
    add(0, 0, 0, 32'h0,            1, 32'h18,       1, 32'hC,        3); // 9 refetch
    add(0, 0, 0, 32'h0,            0, 32'h1C,       1, 32'hC,        4); // 10
    add(0, 1, 0, 32'h0,            0, 32'h1C,       1, 32'hC,        4); // 11
    add(0, 1, 1, 32'h103,          0, 32'h1C,       1, 32'h10,       3); // 12 redirect lvl 3
    add(0, 1, 0, 32'h0,            1, 32'h100,      0, 32'h0,        0); // 13
    add(0, 1, 0, 32'h0,            1, 32'h104,      1, 32'h100,      1); // 14
    add(0, 1, 1, 32'h40,           0, 32'h108,      1, 32'h104,      1); // 15 redirect 0x40
    add(0, 1, 1, 32'h80,           0, 32'h40,       0, 32'h0,        0); // 16 redirect 0x80
    add(0, 1, 0, 32'h0,            1, 32'h80,       0, 32'h0,        0); // 17
    add(0, 1, 0, 32'h0,            1, 32'h84,       1, 32'h80,       1); // 18
    add(0, 1, 1, 32'hFFFF_FFF8,    0, 32'h88,       1, 32'h84,       1); // 19 redirect wrap
    add(0, 1, 0, 32'h0,            1, 32'hFFFF_FFF8, 0, 32'h0,       0); // 20
    add(0, 1, 0, 32'h0,            1, 32'hFFFF_FFFC, 1, 32'hFFFF_FFF8, 1); // 21
    add(0, 1, 0, 32'h0,            1, 32'h0,        1, 32'hFFFF_FFFC, 1); // 22
    add(0, 1, 0, 32'h0,            1, 32'h4,        1, 32'h0,        1); // 23
    add(0, 1, 0, 32'h0,            1, 32'h8,        1, 32'h4,        1); // 24
    add(0, 0, 0, 32'h0,            1, 32'hC,        1, 32'h8,        1); // 25
    add(0, 0, 0, 32'h0,            1, 32'h10,       1, 32'h8,        2); // 26
    add(1, 0, 0, 32'h0,            0, 32'h0,        0, 32'h0,        0); // 27 reset mid-stream
    add(0, 1, 0, 32'h0,            1, 32'h0,        0, 32'h0,        0); // 28
    add(0, 1, 0, 32'h0,            1, 32'h4,        1, 32'h0,        1); // 29

    for (int i = 0; i < vt.size(); i++) begin
      rst           = vt[i].rst;
      inst_ready    = vt[i].ready;
      redirect      = vt[i].redir;
      redirect_addr = vt[i].raddr;
      @(negedge clk);
      chk32("rom_ce",   i, {31'h0, rom_ce},     {31'h0, vt[i].ce});
      chk32("rom_addr", i, rom_addr,            vt[i].addr);
      chk32("valid",    i, {31'h0, inst_valid}, {31'h0, vt[i].valid});
      chk32("pc",       i, pc,                  vt[i].pc);
      chk32("inst",     i, inst,                vt[i].valid ? (vt[i].pc ^ KEY) : 32'h0);
      chk32("level",    i, 32'(level),          32'(vt[i].level));
      @(posedge clk);
      #1;
    end

    total_cnt++;
    if (seen_pc40 == 0) pass_cnt++;
    else $display("FAIL no_pc40: got %0d entries with pc 0x40 expected 0", seen_pc40);

    // Steady-state streaming: one instruction per cycle, PCs strictly +4, no gaps.
    exp_pc = 32'h4;
    rst = 0; redirect = 0; redirect_addr = 0; inst_ready = 1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk32("stream_valid", 100 + i, {31'h0, inst_valid}, 32'h1);
      chk32("stream_pc",    100 + i, pc,   exp_pc);
      chk32("stream_inst",  100 + i, inst, exp_pc ^ KEY);
      chk32("stream_level", 100 + i, 32'(level), 32'd1);
      exp_pc = exp_pc + 32'd4;
      @(posedge clk);
      #1;
    end

    // Head holds stable under backpressure while the queue fills behind it.
    inst_ready = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk32("hold_pc",   200 + i, pc,   exp_pc);
      chk32("hold_inst", 200 + i, inst, exp_pc ^ KEY);
      chk32("hold_level", 200 + i, 32'(level), (i < 3) ? 32'(i + 1) : 32'd4);
      @(posedge clk);
      #1;
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
